// File: rtl/keccak_core_arb.sv
// Two-requester round-robin front end for a shared Keccak core.
// One grant per transaction: the winner's message words are forwarded to the
// core, digest words are routed back, and completion or watchdog abort is
// reported with a one-cycle pulse.
module keccak_core_arb #(
   parameter int unsigned WDOG = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        rq_req,
   input  logic [1:0][2:0]   rq_cmode,
   input  logic [1:0][10:0]  rq_d,
   input  logic [1:0][63:0]  rq_data,
   input  logic [1:0]        rq_valid,
   input  logic [1:0]        rq_last,
   output logic [1:0]        rq_ack,
   output logic [1:0]        rq_gnt,
   output logic [31:0]       rq_hash,
   output logic [1:0]        rq_hash_vld,
   output logic [1:0]        rq_done,
   output logic [1:0]        rq_err,
   output logic              core_start,
   output logic [2:0]        core_cmode,
   output logic [10:0]       core_d,
   output logic [63:0]       core_dt_i,
   output logic              core_last_block,
   input  logic              core_ready,
   input  logic              core_valid,
   input  logic [31:0]       core_dt_o_hash,
   input  logic              core_finish_hash
);

   localparam int unsigned CW = (WDOG > 2) ? $clog2(WDOG) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(WDOG - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic          g_q, g_d;
   logic          last_q, last_d;
   logic [2:0]    cmode_q, cmode_d;
   logic [10:0]   d_q, d_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    err_q, err_d;
   logic          pick;
   logic          xfer;

   // State and transaction context registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         g_q     <= 1'b0;
         last_q  <= 1'b1;
         cmode_q <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         last_q  <= last_d;
         cmode_q <= cmode_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign rq_err = err_q;

   // Next-state, arbitration and per-state output decode
   always_comb begin
      state_d         = state_q;
      g_d             = g_q;
      last_d          = last_q;
      cmode_d         = cmode_q;
      d_d             = d_q;
      cnt_d           = cnt_q;
      err_d           = '0;
      pick            = 1'b0;
      xfer            = 1'b0;
      rq_ack          = '0;
      rq_gnt          = '0;
      rq_hash         = '0;
      rq_hash_vld     = '0;
      rq_done         = '0;
      core_start      = 1'b0;
      core_cmode      = '0;
      core_d          = '0;
      core_dt_i       = '0;
      core_last_block = 1'b0;

      case (state_q)
         S_IDLE: begin
            // On a tie the requester not served last wins
            if (rq_req != 2'b00) begin
               pick    = (rq_req == 2'b11) ? ~last_q : rq_req[1];
               g_d     = pick;
               cmode_d = rq_cmode[pick];
               d_d     = rq_d[pick];
               state_d = S_START;
            end
         end
         S_START: begin
            core_start = 1'b1;
            state_d    = S_FEED;
         end
         S_FEED: begin
            xfer            = rq_valid[g_q] && core_ready;
            core_dt_i       = rq_data[g_q];
            rq_ack[g_q]     = xfer;
            core_last_block = xfer && rq_last[g_q];
            if (xfer && rq_last[g_q]) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            rq_hash          = core_dt_o_hash;
            rq_hash_vld[g_q] = core_valid;
            if (core_finish_hash) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_MAX) begin
               err_d[g_q] = 1'b1;
               last_d     = g_q;
               state_d    = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            rq_done[g_q] = 1'b1;
            last_d       = g_q;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Grant and core configuration are held for the whole transaction
      if (state_q != S_IDLE) begin
         rq_gnt[g_q] = 1'b1;
         core_cmode  = cmode_q;
         core_d      = d_q;
      end
   end

endmodule

// File: tb/tb_keccak_core_arb.sv
// Bench for keccak_core_arb: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_keccak_core_arb;

   logic              clk = 1'b0;
   logic              rst, rst_w;
   logic [1:0]        rq_req, rq_valid, rq_last;
   logic [1:0][2:0]   rq_cmode;
   logic [1:0][10:0]  rq_d;
   logic [1:0][63:0]  rq_data;
   logic              core_ready, core_valid, core_finish_hash;
   logic [31:0]       core_dt_o_hash;

   logic [1:0]  rq_ack, rq_gnt, rq_hash_vld, rq_done, rq_err;
   logic [31:0] rq_hash;
   logic        core_start, core_last_block;
   logic [2:0]  core_cmode;
   logic [10:0] core_d;
   logic [63:0] core_dt_i;

   logic [1:0]  w_rq_ack, w_rq_gnt, w_rq_hash_vld, w_rq_done, w_rq_err;
   logic [31:0] w_rq_hash;
   logic        w_core_start, w_core_last_block;
   logic [2:0]  w_core_cmode;
   logic [10:0] w_core_d;
   logic [63:0] w_core_dt_i;

   int total = 0;
   int passed = 0;
   int last_srv = 1;

   always #5 clk = ~clk;

   keccak_core_arb dut (
      .clk(clk), .rst(rst), .rq_req(rq_req), .rq_cmode(rq_cmode), .rq_d(rq_d),
      .rq_data(rq_data), .rq_valid(rq_valid), .rq_last(rq_last), .rq_ack(rq_ack),
      .rq_gnt(rq_gnt), .rq_hash(rq_hash), .rq_hash_vld(rq_hash_vld), .rq_done(rq_done),
      .rq_err(rq_err), .core_start(core_start), .core_cmode(core_cmode), .core_d(core_d),
      .core_dt_i(core_dt_i), .core_last_block(core_last_block), .core_ready(core_ready),
      .core_valid(core_valid), .core_dt_o_hash(core_dt_o_hash),
      .core_finish_hash(core_finish_hash)
   );

   keccak_core_arb #(.WDOG(8)) dut_wd (
      .clk(clk), .rst(rst_w), .rq_req(rq_req), .rq_cmode(rq_cmode), .rq_d(rq_d),
      .rq_data(rq_data), .rq_valid(rq_valid), .rq_last(rq_last), .rq_ack(w_rq_ack),
      .rq_gnt(w_rq_gnt), .rq_hash(w_rq_hash), .rq_hash_vld(w_rq_hash_vld),
      .rq_done(w_rq_done), .rq_err(w_rq_err), .core_start(w_core_start),
      .core_cmode(w_core_cmode), .core_d(w_core_d), .core_dt_i(w_core_dt_i),
      .core_last_block(w_core_last_block), .core_ready(core_ready),
      .core_valid(core_valid), .core_dt_o_hash(core_dt_o_hash),
      .core_finish_hash(core_finish_hash)
   );

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic [1:0] eg, input logic [1:0] ea,
                          input logic es, input logic [2:0] ec, input logic [10:0] ed,
                          input logic [63:0] edt, input logic elb, input logic [31:0] eh,
                          input logic [1:0] ehv, input logic [1:0] edn, input logic [1:0] eer);
      chk({tag, ".gnt"},   rq_gnt,          eg);
      chk({tag, ".ack"},   rq_ack,          ea);
      chk({tag, ".start"}, core_start,      es);
      chk({tag, ".cmode"}, core_cmode,      ec);
      chk({tag, ".d"},     core_d,          ed);
      chk({tag, ".dt_i"},  core_dt_i,       edt);
      chk({tag, ".lastb"}, core_last_block, elb);
      chk({tag, ".hash"},  rq_hash,         eh);
      chk({tag, ".hvld"},  rq_hash_vld,     ehv);
      chk({tag, ".done"},  rq_done,         edn);
      chk({tag, ".err"},   rq_err,          eer);
   endtask

   // Reset pulse; leaves the bench just after a negedge with the DUT idle
   task automatic do_reset();
      rst = 1'b1; rq_req = 2'b11; core_valid = 1'b1; core_finish_hash = 1'b1;
      @(negedge clk);
      #1 chk_all("in_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0; rq_req = 2'b00; core_valid = 1'b0; core_finish_hash = 1'b0;
      @(negedge clk);
      #1 chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      last_srv = 1;
   endtask

   // One full transaction. mode: 0 random, 1 directed single request,
   // 2 ready toggling 1,0,1.., 3 core_valid on every drain cycle.
   task automatic do_txn(input logic [1:0] req, input int nwords, input int ndig, input int mode);
      int w, sent, cyc, hv_exp, hv_dut;
      logic [2:0]  cm_w;
      logic [10:0] d_w;
      logic [63:0] cur;
      logic [1:0]  eg;
      logic        xa;
      w  = (req == 2'b11) ? (1 - last_srv) : (req[1] ? 1 : 0);
      eg = 2'(1 << w);
      // arbitration cycle
      rq_req = req;
      for (int i = 0; i < 2; i++) begin
         rq_cmode[i] = 3'($urandom);
         rq_d[i]     = 11'($urandom);
         rq_data[i]  = r64();
      end
      if (mode == 1) begin
         rq_cmode[w] = 3'd3;
         rq_d[w]     = 11'd512;
      end
      rq_valid = 2'($urandom); rq_last = 2'($urandom);
      core_ready = 1'($urandom); core_valid = 1'($urandom);
      core_finish_hash = 1'($urandom); core_dt_o_hash = $urandom;
      cm_w = rq_cmode[w]; d_w = rq_d[w]; cur = rq_data[w];
      #1 chk_all("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // start cycle: changed mode/length must not leak through
      @(negedge clk);
      rq_req = 2'($urandom); rq_cmode[w] = 3'($urandom); rq_d[w] = 11'($urandom);
      rq_valid = 2'($urandom);
      #1 chk_all("start", eg, 0, 1, cm_w, d_w, 0, 0, 0, 0, 0, 0);
      // feed
      sent = 0; cyc = 0;
      while (sent < nwords && cyc < 200) begin
         @(negedge clk);
         rq_valid   = (mode == 1 || mode == 2) ? 2'b11 : 2'($urandom);
         core_ready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'(cyc % 2 == 0) : 1'($urandom);
         rq_last    = 2'($urandom);
         rq_last[w] = (sent == nwords - 1);
         rq_data    = {r64(), r64()};
         rq_data[w] = cur;
         rq_req     = 2'($urandom);
         core_valid = 1'($urandom); core_finish_hash = 1'($urandom);
         core_dt_o_hash = $urandom;
         #1 xa = rq_valid[w] && core_ready;
         chk_all("feed", eg, xa ? eg : 2'b00, 0, cm_w, d_w, cur, xa && rq_last[w], 0, 0, 0, 0);
         if (xa) begin
            sent++;
            cur = r64();
         end
         cyc++;
      end
      if (sent < nwords) begin
         total++;
         $error("FAIL feed_timeout: observed %0d words expected %0d", sent, nwords);
      end
      // drain: last digest word coincides with finish
      hv_exp = 0; hv_dut = 0;
      for (int k = 0; k < ndig; k++) begin
         @(negedge clk);
         core_finish_hash = (k == ndig - 1);
         core_valid = (mode == 3 || k == ndig - 1) ? 1'b1 : 1'($urandom);
         core_dt_o_hash = $urandom;
         rq_valid = 2'($urandom); core_ready = 1'($urandom);
         rq_req = 2'($urandom); rq_last = 2'($urandom);
         #1 chk_all("drain", eg, 0, 0, cm_w, d_w, 0, 0, core_dt_o_hash, core_valid ? eg : 2'b00, 0, 0);
         hv_exp += int'(core_valid);
         hv_dut += int'(rq_hash_vld[w]);
      end
      chk("digest_count", 64'(hv_dut), 64'(hv_exp));
      // done: pending requests must not be granted here
      @(negedge clk);
      rq_req = 2'($urandom_range(1, 3)); core_valid = 1'b1;
      core_finish_hash = 1'($urandom); rq_valid = 2'b11; core_ready = 1'b1;
      #1 chk_all("done", eg, 0, 0, cm_w, d_w, 0, 0, 0, 0, eg, 0);
      last_srv = w;
      @(negedge clk);
      rq_req = 2'b00; rq_valid = 2'b00; core_valid = 1'b0; core_finish_hash = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rst_w = 1'b1;
      rq_req = '0; rq_cmode = '0; rq_d = '0; rq_data = '0; rq_valid = '0; rq_last = '0;
      core_ready = 1'b0; core_valid = 1'b0; core_finish_hash = 1'b0; core_dt_o_hash = '0;
      repeat (2) @(negedge clk);
      do_reset();

      // single request, three words, ready held high
      do_txn(2'b01, 3, 4, 1);

      // tie after reset: 0, then 1, then 0
      do_reset();
      do_txn(2'b11, 2, 2, 0);
      do_txn(2'b11, 1, 3, 0);
      do_txn(2'b11, 2, 1, 0);

      // backpressure on requester 1
      do_txn(2'b10, 3, 2, 2);

      // sixteen digest words
      do_txn(2'b01, 2, 16, 3);

      // randomized traffic
      for (int t = 0; t < 20; t++)
         do_txn(2'($urandom_range(1, 3)), $urandom_range(1, 5), $urandom_range(1, 6), 0);

      // reset mid-transaction after requester 0 was served last
      do_txn(2'b01, 1, 1, 0);
      rq_req = 2'b01;
      @(negedge clk);
      rq_req = 2'b00;
      @(negedge clk);
      rq_valid = 2'b01; core_ready = 1'b0; rq_data[0] = r64();
      #1 chk("rst_mid.gnt", rq_gnt, 2'b01);
      chk("rst_mid.dt_i", core_dt_i, rq_data[0]);
      do_reset();
      @(negedge clk);
      core_finish_hash = 1'b1; core_valid = 1'b1; core_dt_o_hash = $urandom;
      #1 chk_all("late_finish", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      core_finish_hash = 1'b0; core_valid = 1'b0; rq_valid = 2'b00;
      #1 chk_all("late_finish2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_txn(2'b11, 1, 2, 0);

      // watchdog on the WDOG=8 instance
      rst_w = 1'b0;
      @(negedge clk);
      rq_req = 2'b10; rq_valid = 2'b00;
      #1 chk("wd.idle_gnt", w_rq_gnt, 2'b00);
      @(negedge clk);
      rq_req = 2'b00;
      #1 chk("wd.start", w_core_start, 1'b1);
      chk("wd.gnt", w_rq_gnt, 2'b10);
      @(negedge clk);
      rq_valid = 2'b10; rq_last = 2'b10; core_ready = 1'b1; rq_data[1] = r64();
      #1 chk("wd.ack", w_rq_ack, 2'b10);
      chk("wd.lastb", w_core_last_block, 1'b1);
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         rq_valid = 2'b00; rq_last = 2'b00; core_valid = 1'b0; core_finish_hash = 1'b0;
         #1 chk("wd.err", w_rq_err, (k == 8) ? 2'b10 : 2'b00);
         chk("wd.gnt_drain", w_rq_gnt, (k == 8) ? 2'b00 : 2'b10);
         chk("wd.done", w_rq_done, 2'b00);
         chk("wd.main_gnt", rq_gnt, 2'b10);
         chk("wd.main_err", rq_err, 2'b00);
      end
      @(negedge clk);
      core_finish_hash = 1'b1; core_valid = 1'b1; core_dt_o_hash = $urandom;
      #1 chk("wd.err_once", w_rq_err, 2'b00);
      chk("wd.gnt_after", w_rq_gnt, 2'b00);
      chk("wd.done_after", w_rq_done, 2'b00);
      chk("wd.main_hvld", rq_hash_vld, 2'b10);
      chk("wd.main_hash", rq_hash, core_dt_o_hash);
      @(negedge clk);
      core_finish_hash = 1'b0; core_valid = 1'b0;
      #1 chk("wd.main_done", rq_done, 2'b10);
      chk("wd.wd_done", w_rq_done, 2'b00);
      last_srv = 1;
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/keccak_core_arb.md
KECCAK_CORE_ARB -- requirements
Module: keccak_core_arb

Interface
REQ-001 SHALL have parameter WDOG, default 4096: maximum cycles allowed in DRAIN before abort.
REQ-002 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port rq_req  in  2  per-requester hash request, bit i = requester i.
REQ-005 SHALL have port rq_cmode  in  2x3  per-requester hash mode.
REQ-006 SHALL have port rq_d  in  2x11  per-requester output length.
REQ-007 SHALL have port rq_data  in  2x64  per-requester message word.
REQ-008 SHALL have port rq_valid  in  2  per-requester message word valid.
REQ-009 SHALL have port rq_last  in  2  per-requester final-word flag, qualified by rq_valid.
REQ-010 SHALL have port rq_ack  out  2  message word accepted this cycle.
REQ-011 SHALL have port rq_gnt  out  2  one-hot grant (or zero).
REQ-012 SHALL have port rq_hash  out  32  digest word, shared by both requesters.
REQ-013 SHALL have port rq_hash_vld  out  2  digest word valid for requester i.
REQ-014 SHALL have port rq_done  out  2  one-cycle completion pulse.
REQ-015 SHALL have port rq_err  out  2  one-cycle watchdog-abort pulse.
REQ-016 SHALL have port core_start  out  1  one-cycle start pulse to the Keccak core.
REQ-017 SHALL have port core_cmode  out  3  mode to the core.
REQ-018 SHALL have port core_d  out  11  output length to the core.
REQ-019 SHALL have port core_dt_i  out  64  message word to the core.
REQ-020 SHALL have port core_last_block  out  1  marks the final word to the core.
REQ-021 SHALL have port core_ready  in  1  core samples core_dt_i this cycle when high.
REQ-022 SHALL have port core_valid  in  1  core digest word valid.
REQ-023 SHALL have port core_dt_o_hash  in  32  core digest word.
REQ-024 SHALL have port core_finish_hash  in  1  core hash complete pulse.

Function
REQ-025 SHALL implement the states IDLE, START, FEED, DRAIN and DONE.
REQ-026 SHALL perform the following in IDLE: when rq_req is nonzero, grant round-robin; the requester not served last wins a tie; after reset, requester 0 wins the first tie; latch rq_cmode[g] and rq_d[g]; go to START.
REQ-027 SHALL set rq_gnt one-hot from the cycle after the IDLE decision until the end of DONE.
REQ-028 SHALL hold core_cmode and core_d at the latched values from START until the return to IDLE, and at 0 otherwise.
REQ-029 SHALL perform the following in START: assert core_start for exactly one cycle, then go to FEED.
REQ-030 SHALL perform the following in FEED: core_dt_i=rq_data[g]; a transfer occurs when rq_valid[g] && core_ready; rq_ack[g]=transfer; core_last_block=transfer && rq_last[g]; a transfer with rq_last goes to DRAIN.
REQ-031 SHALL hold core_dt_i at 0, and rq_ack and core_last_block low, outside FEED.
REQ-032 SHALL never assert rq_ack for the non-granted requester; its rq_valid is ignored.
REQ-033 SHALL perform the following in DRAIN: rq_hash=core_dt_o_hash, rq_hash_vld[g]=core_valid, combinationally; on core_finish_hash go to DONE; core_valid and core_finish_hash outside DRAIN are ignored.
REQ-034 SHALL forward the final digest word when core_valid and core_finish_hash coincide, then go to DONE.
REQ-035 SHALL perform the following in DONE: pulse rq_done[g] for one cycle, record g as last served, clear the grant, then go to IDLE; the next grant occurs no earlier than the cycle after IDLE.
REQ-036 SHALL maintain a DRAIN cycle counter, cleared on entry; if it reaches WDOG-1 without core_finish_hash, pulse rq_err[g], leave rq_done low, update the last-served pointer, clear the grant, and go to IDLE.
REQ-037 SHALL let the current transaction complete when rq_req[g] drops after the grant; rq_req is sampled only in IDLE.
REQ-038 SHALL give one new grant per transaction; there is no preemption.

Reset
REQ-039 SHALL, when rst is high at a clock edge, enter IDLE, clear rq_gnt, rq_ack, rq_hash_vld, rq_done, rq_err, core_start, core_last_block, core_cmode, core_d and the watchdog counter, and set the last-served pointer to 1.
REQ-040 SHALL apply reset mid-transaction with no done or err pulse; the core is not notified, and a core_finish_hash arriving later is ignored.
REQ-041 SHALL drive all outputs to 0 in the cycle after reset is released.

Verification
REQ-042 SHALL cover a single request: rq_req=01, cmode=3, d=512, three words with last on the third, core_ready=1 -> grant 01, one core_start, three acks, core_last_block on word 3, rq_done[0] after finish_hash.
REQ-043 SHALL cover a tie: rq_req=11 after reset -> requester 0 served, then requester 1, then requester 0 again when both are still pending.
REQ-044 SHALL cover backpressure: core_ready toggling 1,0,1 with rq_valid=1 -> rq_ack only on ready cycles, and core_dt_i stable while stalled.
REQ-045 SHALL cover digest forwarding: 16 core_valid pulses in DRAIN, the last coinciding with finish_hash -> 16 rq_hash_vld[g] pulses carrying matching data, then rq_done.
REQ-046 SHALL cover the watchdog: WDOG=8 with no finish_hash -> rq_err[g] 8 cycles after DRAIN entry, no rq_done, grant cleared.
REQ-047 SHALL cover reset mid-transaction: rst in FEED -> all outputs 0, IDLE, and requester 0 wins the next tie.
